// File: rtl/store_merge_sequencer.sv
// +----------------------------------------------------------------------------+
// | store_merge_sequencer: read-modify-write sequencer for sub-word stores       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_merge_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_enable,
    input  logic                          req_valid,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [$clog2($clog2(DATA_WIDTH/8)+1)-1:0] req_size,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          stall,
    output logic                          done,
    output logic                          misaligned,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [DATA_WIDTH-1:0]         mem_writedata,
    input  logic [DATA_WIDTH-1:0]         mem_readdata,
    input  logic                          mem_waitrequest
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);
    localparam int SZ_W  = $clog2(LB + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_MERGE = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SZ_W-1:0]       r_size;
    logic [LB-1:0]         r_offset;

    logic                  w_full;
    logic                  w_reject;
    logic [LB:0]           w_nbytes;
    logic [LB:0]           w_lane_sh;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_merged;

    // Low req_size bits of the lane offset must be zero; oversize requests are rejected outright.
    assign w_full   = (req_size == SZ_W'(LB));
    assign w_reject = (req_size > SZ_W'(LB)) ||
                      ((req_addr[LB-1:0] & ~({LB{1'b1}} << req_size)) != '0);

    assign w_nbytes = (LB+1)'(1) << r_size;
    assign w_mask   = ~({DATA_WIDTH{1'b1}} << {w_nbytes, 3'b000});

    // In both byte orders the source field lands as one contiguous shifted block.
    generate
        if (BIG_ENDIAN) begin : g_big_endian
            assign w_lane_sh = (LB+1)'(LANES) - w_nbytes - {1'b0, r_offset};
        end else begin : g_little_endian
            assign w_lane_sh = {1'b0, r_offset};
        end
    endgenerate

    assign w_merged = (r_merge & ~(w_mask << {w_lane_sh, 3'b000})) |
                      ((r_wdata & w_mask) << {w_lane_sh, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (clk_enable) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (req_valid && !w_reject) begin
                    w_next = w_full ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    w_next = S_MERGE;
                end
            end
            S_MERGE: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done          <= 1'b0;
            misaligned    <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            r_merge       <= '0;
            r_wdata       <= '0;
            r_size        <= '0;
            r_offset      <= '0;
        end else if (clk_enable) begin
            done       <= (r_state == S_WRITE) && !mem_waitrequest;
            misaligned <= (r_state == S_IDLE) && req_valid && w_reject;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !w_reject) begin
                        mem_address <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                        r_size      <= req_size;
                        r_offset    <= req_addr[LB-1:0];
                        r_wdata     <= req_wdata;
                        if (w_full) begin
                            mem_writedata <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (!mem_waitrequest) begin
                        r_merge <= mem_readdata;
                    end
                end
                S_MERGE: begin
                    mem_writedata <= w_merged;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
